fp_div_sqrt_arbiter: RTL and testbench
======================================

FP_DIV_SQRT_ARBITER -- requirements
Module: fp_div_sqrt_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, the number of requesters (2..8).
REQ-002 SHALL have parameter TAG_WIDTH, default 6, the width of the opaque requester tag.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits, one request-valid per requester.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits, one-hot grant.
REQ-007 SHALL have ports req_lhs and req_rhs, inputs, NUM_REQ x 32 bits, the FP32 operands.
REQ-008 SHALL have port req_is_divide, input, NUM_REQ bits: 1 selects lhs/rhs, 0 selects sqrt(lhs).
REQ-009 SHALL have port req_tag, input, NUM_REQ x TAG_WIDTH bits.
REQ-010 SHALL have ports unit_req (1), unit_lhs (32), unit_rhs (32) and unit_is_divide (1), outputs, driving the FP32 div/sqrt unit.
REQ-011 SHALL have ports unit_finished (1) and unit_result (32), inputs, from the unit.
REQ-012 SHALL have ports resp_valid (1), resp_id (clog2(NUM_REQ)), resp_tag (TAG_WIDTH) and resp_result (32), outputs.
REQ-013 SHALL have port resp_ready, input, 1 bit.
REQ-014 SHALL have port flush, input, 1 bit, which kills the operation in flight.

Function
REQ-015 SHALL implement the FSM IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
REQ-016 SHALL grant in IDLE only when unit_finished=1, flush=0 and any req_valid=1; the grant is same-cycle and combinational.
REQ-017 SHALL, in the grant cycle, assert unit_req=1, assert the winner's req_ready bit, drive the winner's operands onto unit_*, latch id and tag, and go to LAUNCH.
REQ-018 SHALL hold unit_req=0 and all req_ready bits 0 in every cycle that is not a grant cycle.
REQ-019 SHALL arbitrate round-robin: search starts at last_grant+1 modulo NUM_REQ, and last_grant updates on each grant.
REQ-020 SHALL spend exactly one cycle in LAUNCH, then enter WAIT; unit_finished is ignored in LAUNCH.
REQ-021 SHALL, in WAIT, capture unit_result into resp_result when unit_finished=1 and go to RESP.
REQ-022 SHALL hold resp_valid=1 in RESP with resp_id, resp_tag and resp_result stable until resp_ready=1, then go to IDLE.
REQ-023 SHALL allow a new grant no earlier than the cycle after the response handshake.
REQ-024 SHALL, when flush=1 in LAUNCH or WAIT, set a killed flag; the result is then discarded on unit_finished and the FSM goes to IDLE with no resp_valid.
REQ-025 SHALL, when flush=1 in RESP, drop the response and go to IDLE in the next cycle.
REQ-026 SHALL give flush precedence over a simultaneous resp_ready.
REQ-027 SHALL NOT grant while flush=1 in IDLE.
REQ-028 SHALL have divide latency: grant at cycle 0, unit_finished rises at cycle 16, resp_valid at cycle 17.
REQ-029 SHALL have sqrt latency: unit_finished rises at cycle 15, resp_valid at cycle 16.

Reset
REQ-030 SHALL, on rst=1, asynchronously enter IDLE, clear the killed flag and set last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-031 SHALL, on rst=1, force req_ready=0, unit_req=0, resp_valid=0 and resp_id/resp_tag/resp_result=0.
REQ-032 SHALL, on rst mid-operation, abandon the operation; no response follows, and the unit shares the same rst.

Configuration
REQ-033 SHALL, when FP_DIV_SQRT_ARB_FAST_RESP_EN is defined:
- in WAIT with unit_finished=1 and not killed, drive resp_valid=1 combinationally, with resp_result=unit_result;
- if resp_ready=1 in that cycle, go directly to IDLE; otherwise latch the result and go to RESP.
- Divide response then appears at cycle 16, sqrt at cycle 15.
REQ-034 SHALL, when FP_DIV_SQRT_ARB_FAST_RESP_EN is undefined, assert resp_valid only in RESP, registered, per REQ-021/022.

Verification
REQ-035 Single divide: req_valid=01, lhs=0x40C00000, rhs=0x40000000, divide, tag=5 -> req_ready=01 at cycle 0; resp_valid at cycle 17 with result=0x40400000, id=0, tag=5.
REQ-036 Sqrt: lhs=0x40800000, is_divide=0 on requester 1 -> resp_valid at cycle 16 with result=0x40000000, id=1.
REQ-037 Contention: req_valid=11 held through four operations -> grant order 0,1,0,1, with no grant while busy.
REQ-038 Backpressure: resp_ready=0 for 10 cycles in RESP -> outputs held stable, req_ready stays 0, next grant on the cycle after the handshake.
REQ-039 Flush: flush=1 at cycle 5 of a divide -> no resp_valid, IDLE at cycle 17, and the next grant succeeds with a correct result.
REQ-040 Reset: rst pulsed at cycle 8 of a divide -> all outputs 0 immediately, no response, first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/fp_div_sqrt_arbiter.sv
// Round-robin arbiter sharing one FP32 div/sqrt unit among NUM_REQ requesters.
// Define FP_DIV_SQRT_ARB_FAST_RESP_EN to forward the result in the unit's finish cycle.
module fp_div_sqrt_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int TAG_WIDTH = 6,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][31:0]          req_lhs,
    input  logic [NUM_REQ-1:0][31:0]          req_rhs,
    input  logic [NUM_REQ-1:0]                req_is_divide,
    input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0] req_tag,
    output logic                              unit_req,
    output logic [31:0]                       unit_lhs,
    output logic [31:0]                       unit_rhs,
    output logic                              unit_is_divide,
    input  logic                              unit_finished,
    input  logic [31:0]                       unit_result,
    output logic                              resp_valid,
    output logic [ID_W-1:0]                   resp_id,
    output logic [TAG_WIDTH-1:0]              resp_tag,
    output logic [31:0]                       resp_result,
    input  logic                              resp_ready,
    input  logic                              flush
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               r_state;
    logic                 r_killed;
    logic [ID_W-1:0]      r_last;
    logic                 r_resp_valid;
    logic [ID_W-1:0]      r_resp_id;
    logic [TAG_WIDTH-1:0] r_resp_tag;
    logic [31:0]          r_resp_result;

    logic                 w_found;
    logic [ID_W-1:0]      w_win_id;
    logic [ID_W-1:0]      w_idx;
    logic                 w_grant;
    logic                 w_fast;

    // Search starts one past the previous winner.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && !rst && unit_finished
                   && !flush && w_found;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_win_id] = 1'b1;
        end
    end

    assign unit_req       = w_grant;
    assign unit_lhs       = w_grant ? req_lhs[w_win_id] : '0;
    assign unit_rhs       = w_grant ? req_rhs[w_win_id] : '0;
    assign unit_is_divide = w_grant ? req_is_divide[w_win_id] : 1'b0;

`ifdef FP_DIV_SQRT_ARB_FAST_RESP_EN
    assign w_fast = (r_state == S_WAIT) && unit_finished
                  && !r_killed && !flush;
`else
    assign w_fast = 1'b0;
`endif

    assign resp_valid  = r_resp_valid | w_fast;
    assign resp_result = w_fast ? unit_result : r_resp_result;
    assign resp_id     = r_resp_id;
    assign resp_tag    = r_resp_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_killed      <= 1'b0;
            r_last        <= ID_W'(NUM_REQ - 1);
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_tag    <= '0;
            r_resp_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state    <= S_LAUNCH;
                        r_last     <= w_win_id;
                        r_resp_id  <= w_win_id;
                        r_resp_tag <= req_tag[w_win_id];
                        r_killed   <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT;
                    if (flush) begin
                        r_killed <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (unit_finished) begin
                        r_killed <= 1'b0;
                        // A flush landing on the finish cycle also kills.
                        if (r_killed || flush) begin
                            r_state <= S_IDLE;
                        end else if (w_fast && resp_ready) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state       <= S_RESP;
                            r_resp_valid  <= 1'b1;
                            r_resp_result <= unit_result;
                        end
                    end else if (flush) begin
                        r_killed <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (flush || resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_sqrt_arbiter.sv
// Scoreboard bench for fp_div_sqrt_arbiter with a behavioural div/sqrt unit
// and a round-robin reference model.
module tb_fp_div_sqrt_arbiter;

    localparam int N  = 2;
    localparam int TW = 6;
    localparam int IW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][31:0]   req_lhs;
    logic [N-1:0][31:0]   req_rhs;
    logic [N-1:0]         req_is_divide;
    logic [N-1:0][TW-1:0] req_tag;
    logic                 unit_req;
    logic [31:0]          unit_lhs;
    logic [31:0]          unit_rhs;
    logic                 unit_is_divide;
    logic                 unit_finished;
    logic [31:0]          unit_result;
    logic                 resp_valid;
    logic [IW-1:0]        resp_id;
    logic [TW-1:0]        resp_tag;
    logic [31:0]          resp_result;
    logic                 resp_ready;
    logic                 flush;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          id;
        logic [TW-1:0] tag;
        logic [31:0] res;
        int          g;
        int          fin;
        int          due;
        bit          killed;
    } exp_t;

    exp_t q[$];
    int   grant_log[$];
    bit   ref_busy       = 1'b0;
    int   ref_last       = N - 1;
    int   last_grant_cyc = -1;
    int   last_hs_cyc    = -1;

    fp_div_sqrt_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_lhs(req_lhs), .req_rhs(req_rhs),
        .req_is_divide(req_is_divide), .req_tag(req_tag),
        .unit_req(unit_req), .unit_lhs(unit_lhs), .unit_rhs(unit_rhs),
        .unit_is_divide(unit_is_divide),
        .unit_finished(unit_finished), .unit_result(unit_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_tag(resp_tag),
        .resp_result(resp_result), .resp_ready(resp_ready), .flush(flush)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural unit: known FP cases exact, otherwise a fixed operand hash.
    function automatic logic [31:0] unit_fn(logic [31:0] a, logic [31:0] b,
                                            logic d);
        if (d && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (!d && a == 32'h40800000) return 32'h40000000;
        if (d) return (a ^ {b[15:0], b[31:16]}) + 32'd1;
        return ~a;
    endfunction

    int          u_cnt;
    logic [31:0] u_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_cnt <= 0;
            u_res <= '0;
        end else if (u_cnt > 0) begin
            u_cnt <= u_cnt - 1;
        end else if (unit_req) begin
            u_cnt <= unit_is_divide ? 15 : 14;
            u_res <= unit_fn(unit_lhs, unit_rhs, unit_is_divide);
        end
    end
    assign unit_finished = (u_cnt == 0);
    assign unit_result   = u_res;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor and reference model.
    always @(negedge clk) begin : mon
        int           eg;
        int           j;
        logic [N-1:0] er;
        bit           exp_rv;
        exp_t         e;
        if (rst) begin
            chk("rst_outputs", {req_ready, unit_req, resp_valid, resp_id,
                                resp_tag, resp_result}, '0);
            q.delete();
            ref_busy = 1'b0;
            ref_last = N - 1;
        end else begin
            eg = -1;
            if (!ref_busy && unit_finished && !flush) begin
                for (int k = 1; k <= N; k++) begin
                    j = (ref_last + k) % N;
                    if (eg < 0 && req_valid[j]) eg = j;
                end
            end
            er = '0;
            if (eg >= 0) er[eg] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("unit_req", unit_req, eg >= 0);
            if (eg >= 0) begin
                chk("unit_lhs", unit_lhs, req_lhs[eg]);
                chk("unit_rhs", unit_rhs, req_rhs[eg]);
                chk("unit_is_divide", unit_is_divide, req_is_divide[eg]);
                e.id     = eg;
                e.tag    = req_tag[eg];
                e.res    = unit_fn(req_lhs[eg], req_rhs[eg], req_is_divide[eg]);
                e.g      = cyc;
                e.fin    = cyc + (req_is_divide[eg] ? 16 : 15);
                e.due    = e.fin + 1;
                e.killed = 1'b0;
                q.push_back(e);
                ref_busy       = 1'b1;
                ref_last       = eg;
                last_grant_cyc = cyc;
                grant_log.push_back(eg);
            end else if (flush && q.size() > 0 && !q[0].killed
                         && cyc > q[0].g && cyc < q[0].fin) begin
                q[0].killed = 1'b1;
            end
            exp_rv = q.size() > 0 && !q[0].killed && cyc >= q[0].due;
            chk("resp_valid", resp_valid, exp_rv);
            if (exp_rv && resp_valid) begin
                chk("resp_id", resp_id, q[0].id);
                chk("resp_tag", resp_tag, q[0].tag);
                chk("resp_result", resp_result, q[0].res);
            end
            if (exp_rv && (flush || resp_ready)) begin
                if (!flush) last_hs_cyc = cyc;
                void'(q.pop_front());
                ref_busy = 1'b0;
            end else if (q.size() > 0 && q[0].killed && cyc >= q[0].fin) begin
                void'(q.pop_front());
                ref_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic d,
                           logic [TW-1:0] t);
        req_valid[i]     = 1'b1;
        req_lhs[i]       = a;
        req_rhs[i]       = b;
        req_is_divide[i] = d;
        req_tag[i]       = t;
    endtask

    task automatic wait_grant(int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 300);
        chk("grant_wait", req_ready[i], 1'b1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic idle_wait();
        int n;
        n = 0;
        while ((ref_busy || q.size() > 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", ref_busy, 1'b0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           g;
        int           n;
        logic [N-1:0] gm;
        rst           = 1'b1;
        req_valid     = '0;
        req_lhs       = '0;
        req_rhs       = '0;
        req_is_divide = '0;
        req_tag       = '0;
        resp_ready    = 1'b1;
        flush         = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b0;

        // Divide 6/2 on requester 0
        tick();
        set_req(0, 32'h40C00000, 32'h40000000, 1'b1, 6'd5);
        wait_grant(0);
        idle_wait();

        // sqrt(4) on requester 1
        set_req(1, 32'h40800000, 32'h0, 1'b0, 6'd9);
        wait_grant(1);
        idle_wait();

        // Contention: both held through four operations
        grant_log.delete();
        set_req(0, $urandom, $urandom, 1'b1, 6'd1);
        set_req(1, $urandom, $urandom, 1'b0, 6'd2);
        n = 0;
        while (grant_log.size() < 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tick();
        req_valid = '0;
        chk("rr_count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            chk("rr_order", grant_log[k], k % 2);
        idle_wait();

        // Backpressure for 10 cycles in RESP
        resp_ready = 1'b0;
        set_req(0, $urandom, $urandom, 1'b1, 6'd11);
        wait_grant(0);
        set_req(1, $urandom, $urandom, 1'b1, 6'd12);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_resp_seen", resp_valid, 1'b1);
        repeat (10) @(negedge clk);
        tick();
        resp_ready = 1'b1;
        wait_grant(1);
        chk("bp_next_grant", last_grant_cyc, last_hs_cyc + 1);
        idle_wait();

        // Flush at cycle 5 of a divide
        set_req(0, 32'h40C00000, 32'h40000000, 1'b1, 6'd7);
        wait_grant(0);
        g = last_grant_cyc;
        while (cyc < g + 5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_req(0, 32'h40C00000, 32'h40000000, 1'b1, 6'd8);
        wait_grant(0);
        chk("flush_regrant", last_grant_cyc, g + 17);
        idle_wait();

        // Reset at cycle 8 of a divide
        set_req(1, $urandom, $urandom, 1'b1, 6'd3);
        wait_grant(1);
        g = last_grant_cyc;
        while (cyc < g + 8) tick();
        set_req(0, $urandom, $urandom, 1'b1, 6'd20);
        set_req(1, $urandom, $urandom, 1'b0, 6'd21);
        rst = 1'b1;
        #1;
        chk("rst_async", {req_ready, unit_req, resp_valid, resp_id,
                          resp_tag, resp_result}, '0);
        repeat (2) tick();
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 50);
        chk("post_rst_grant", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        wait_grant(1);
        idle_wait();

        // Randomised traffic with backpressure and occasional flush
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gm = req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || gm[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, $urandom, $urandom,
                                1'($urandom_range(0, 1)), TW'($urandom));
                    else
                        req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 40) == 0)
                  && !(q.size() > 0 && cyc == q[0].fin);
        end
        tick();
        flush      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        idle_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
